conv_output_stage: RTL and testbench
====================================

// Module: conv_output_stage
// PURPOSE
//   Consumes the raw 36-bit MAC stream from the 3x3 convolver and emits one 16-bit feature-map pixel per valid position.
//   Drops the 2 wrap-around columns per row and the 2 warm-up rows, then rounds, shifts, saturates and applies optional ReLU.
//   Buffers results in a small FIFO so a stalled consumer (writeback/DMA) never stalls the convolver.
// PARAMETERS
//   MAC_W     36  width of the incoming MAC word (two's complement)
//   PIX_W     16  width of the output pixel (two's complement)
//   DIM_W     10  width of the image row/column size inputs
//   FIFO_DEP  4   output FIFO depth; power of 2, >= 2
// PORTS
//   clk          in   1       clock, all logic on the rising edge
//   rst          in   1       synchronous, active-high reset
//   start        in   1       1-cycle pulse; latches config and clears counters
//   img_w        in   DIM_W   input image width W (>= 3); sampled on start
//   img_h        in   DIM_W   input image height H (>= 3); sampled on start
//   frac_shift   in   5       arithmetic right shift 0..20; sampled on start
//   relu_en      in   1       1 = clamp negatives to 0; sampled on start
//   mac_valid    in   1       in_mac carries a convolver result this cycle
//   in_mac       in   MAC_W   convolver output_mac
//   out_valid    out  1       out_data valid (FIFO not empty)
//   out_ready    in   1       consumer accepts out_data when out_valid & out_ready
//   out_data     out  PIX_W   quantized pixel, row-major, (W-2)*(H-2) per frame
//   frame_done   out  1       1-cycle pulse when the last valid pixel enters the FIFO
//   sat_flag     out  1       sticky: some pixel saturated since start
//   ovf_err      out  1       sticky: pixel dropped because the FIFO was full
// BEHAVIOUR
//   Reset: out_valid=0, out_data=0, frame_done=0, sat_flag=0, ovf_err=0; counters=0; FIFO empty; config regs=0.
//   start: clears col/row counters, sat_flag, ovf_err and the FIFO; latches config. start wins over a coincident mac_valid (that sample is dropped).
//   States: IDLE -> (start) RUN -> (last pixel accepted) DONE -> (start) RUN. mac_valid is ignored in IDLE and DONE.
//   Counting in RUN, once per mac_valid:
//   - col runs 0..W-1 and wraps to 0, then row increments.
//   - Keep the sample iff col <= W-3; everything else is discarded.
//   - row runs 0..H-3. After the kept sample at (row H-3, col W-3), frame_done fires 3 cycles later (after pipeline stage 3).
//   Pipeline, fixed 3-cycle latency from mac_valid to FIFO write:
//   - S1: add bias r = (frac_shift==0) ? 0 : 1<<(frac_shift-1) (round half up), result in MAC_W+1 bits.
//   - S2: arithmetic >>> frac_shift.
//   - S3: saturate to [-32768, 32767] and set sat_flag if clipped; then, if relu_en, negatives become 0. ReLU-zeroed values do not set sat_flag.
//   FIFO:
//   - Write is the S3 valid. Read is out_valid & out_ready. Simultaneous read and write when full is allowed, with no drop.
//   - Write while full with no read: the pixel is dropped and ovf_err is set.
//   - out_data is the FIFO head. It is held stable while out_valid & !out_ready.
//   - Empty: out_valid=0. out_data keeps its last value (0 after reset).
//   rst mid-frame: everything returns to reset values in the next cycle; in-flight pipeline data is discarded.
//   No stall input toward the convolver. Back-pressure is absorbed only by the FIFO.
// STRUCTURE
//   Shared header.vh holds MAC_W, PIX_W and DIM_W defaults, the PIX_MAX/PIX_MIN constants and the IDLE/RUN/DONE state encodings.
//   Sub-module sync_fifo (WIDTH=PIX_W, DEPTH=FIFO_DEP): single clock, synchronous reset, full/empty, registered head.
//   Counters, state machine and the 3-stage quantizer stay in this module.
// TESTING
//   1 W=H=5, shift=0, relu=0, in_mac=col+10*row, out_ready=1 -> exactly 9 outputs: 0,1,2,10,11,12,20,21,22; frame_done once, 3 cycles after sample (2,2).
//   2 shift=4, in_mac=24 / 23 / -24 -> 2 / 1 / -1 (half-up rounding); in_mac=0x0_0010_0000 with shift=4 -> 32767 and sat_flag=1.
//   3 relu=1, shift=0, in_mac=-5 -> 0 with sat_flag=0; in_mac=-40000, relu=0 -> -32768 and sat_flag=1.
//   4 W=H=6, out_ready=0 for the first 8 kept pixels -> first 4 retained, ovf_err=1; releasing ready drains them in order.
//   5 out_ready toggled 1-0-1 every cycle for a full 6x6 frame -> all 16 pixels delivered in order, no loss, ovf_err=0.
//   6 rst asserted mid-frame, then start with W=H=4 -> no stale pixels; 4 fresh outputs; flags clear.

Source files
------------

// File: rtl/conv_output_stage_pkg.sv
// Shared constants and state encoding for the convolver output stage.
package conv_output_stage_pkg;

    localparam int DEF_MAC_W    = 36;
    localparam int DEF_PIX_W    = 16;
    localparam int DEF_DIM_W    = 10;
    localparam int DEF_FIFO_DEP = 4;

    localparam logic [15:0] PIX_MAX = 16'h7FFF;
    localparam logic [15:0] PIX_MIN = 16'h8000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/conv_output_stage_sync_fifo.sv
// Single-clock FIFO with a registered head word; the head keeps its last value when the FIFO drains.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] head_q;
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      rd_ptr_nxt;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign count      = wr_ptr_q - rd_ptr_q;
    assign empty_o    = (count == '0);
    assign full_o     = (count == (AW+1)'(DEPTH));
    assign do_rd      = rd_en_i & ~empty_o;
    // A read in the same cycle frees the slot, so a full FIFO still accepts the write.
    assign do_wr      = wr_en_i & (~full_o | do_rd);
    assign rd_ptr_nxt = rd_ptr_q + (AW+1)'(1);
    assign rd_data_o  = head_q;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            head_q   <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_nxt;
            end
            // Head comes straight from the write port when the new word becomes the only entry.
            if (do_wr && (empty_o || (do_rd && count == (AW+1)'(1)))) begin
                head_q <= wr_data_i;
            end else if (do_rd && count > (AW+1)'(1)) begin
                head_q <= mem_q[rd_ptr_nxt[AW-1:0]];
            end
        end
    end

endmodule

// File: rtl/conv_output_stage.sv
// Turns the raw 3x3 convolver MAC stream into quantized pixels: position filter, round/shift/saturate/ReLU, output FIFO.
module conv_output_stage
    import conv_output_stage_pkg::*;
#(
    parameter int MAC_W    = DEF_MAC_W,
    parameter int PIX_W    = DEF_PIX_W,
    parameter int DIM_W    = DEF_DIM_W,
    parameter int FIFO_DEP = DEF_FIFO_DEP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [DIM_W-1:0] img_w,
    input  logic [DIM_W-1:0] img_h,
    input  logic [4:0]       frac_shift,
    input  logic             relu_en,
    input  logic             mac_valid,
    input  logic [MAC_W-1:0] in_mac,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [PIX_W-1:0] out_data,
    output logic             frame_done,
    output logic             sat_flag,
    output logic             ovf_err,
    output state_e           dbg_state_o
);
    localparam logic [DIM_W-1:0] ONE   = DIM_W'(1);
    localparam logic [DIM_W-1:0] THREE = DIM_W'(3);
    localparam logic signed [MAC_W:0] SAT_HI =
        $signed({{(MAC_W+2-PIX_W){1'b0}}, {(PIX_W-1){1'b1}}});
    localparam logic signed [MAC_W:0] SAT_LO =
        $signed({{(MAC_W+2-PIX_W){1'b1}}, {(PIX_W-1){1'b0}}});
    localparam logic [PIX_W-1:0] P_MAX = {1'b0, {(PIX_W-1){1'b1}}};
    localparam logic [PIX_W-1:0] P_MIN = {1'b1, {(PIX_W-1){1'b0}}};

    state_e           state_q, state_d;
    logic [DIM_W-1:0] col_q, col_d;
    logic [DIM_W-1:0] row_q, row_d;
    logic [DIM_W-1:0] w_q, h_q;
    logic [4:0]       shift_q;
    logic             relu_q;
    logic             keep_c, last_c;

    logic                    s1_valid_q, s1_last_q;
    logic signed [MAC_W:0]   s1_sum_q;
    logic                    s2_valid_q, s2_last_q;
    logic signed [MAC_W:0]   s2_val_q;
    logic                    s3_valid_q, s3_last_q;
    logic [PIX_W-1:0]        s3_pix_q;
    logic                    frame_done_q, sat_q, ovf_q;

    logic signed [MAC_W:0]   bias;
    logic signed [MAC_W:0]   in_ext;
    logic [PIX_W-1:0]        pix_c;
    logic                    clip_c;
    logic                    fifo_empty, fifo_full, fifo_rd;

    assign dbg_state_o = state_q;
    assign frame_done  = frame_done_q;
    assign sat_flag    = sat_q;
    assign ovf_err     = ovf_q;
    assign out_valid   = ~fifo_empty;
    assign fifo_rd     = out_valid & out_ready;
    assign in_ext      = $signed({in_mac[MAC_W-1], in_mac});

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            col_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
        end
    end

    // A start pulse restarts the frame and swallows any sample presented alongside it.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        keep_c  = 1'b0;
        last_c  = 1'b0;
        if (start) begin
            state_d = ST_RUN;
            col_d   = '0;
            row_d   = '0;
        end else if (state_q == ST_RUN && mac_valid) begin
            keep_c = (col_q <= w_q - THREE);
            last_c = keep_c && (row_q == h_q - THREE) && (col_q == w_q - THREE);
            if (col_q == w_q - ONE) begin
                col_d = '0;
                row_d = row_q + ONE;
            end else begin
                col_d = col_q + ONE;
            end
            if (last_c) begin
                state_d = ST_DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_q     <= '0;
            h_q     <= '0;
            shift_q <= '0;
            relu_q  <= 1'b0;
        end else if (start) begin
            w_q     <= img_w;
            h_q     <= img_h;
            shift_q <= frac_shift;
            relu_q  <= relu_en;
        end
    end

    always_comb begin
        bias = '0;
        if (shift_q != 5'd0) begin
            bias = $signed({{MAC_W{1'b0}}, 1'b1} << (shift_q - 5'd1));
        end
    end

    // Clipping is judged before ReLU so a zeroed negative never counts as saturated.
    always_comb begin
        clip_c = 1'b0;
        pix_c  = s2_val_q[PIX_W-1:0];
        if (s2_val_q > SAT_HI) begin
            pix_c  = P_MAX;
            clip_c = 1'b1;
        end else if (s2_val_q < SAT_LO) begin
            pix_c  = P_MIN;
            clip_c = 1'b1;
        end
        if (relu_q && pix_c[PIX_W-1]) begin
            pix_c  = '0;
            clip_c = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            s1_sum_q     <= '0;
            s2_valid_q   <= 1'b0;
            s2_last_q    <= 1'b0;
            s2_val_q     <= '0;
            s3_valid_q   <= 1'b0;
            s3_last_q    <= 1'b0;
            s3_pix_q     <= '0;
            frame_done_q <= 1'b0;
            sat_q        <= 1'b0;
            ovf_q        <= 1'b0;
        end else if (start) begin
            s1_valid_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_last_q    <= 1'b0;
            s3_valid_q   <= 1'b0;
            s3_last_q    <= 1'b0;
            frame_done_q <= 1'b0;
            sat_q        <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            s1_valid_q   <= keep_c;
            s1_last_q    <= last_c;
            s1_sum_q     <= in_ext + bias;
            s2_valid_q   <= s1_valid_q;
            s2_last_q    <= s1_last_q;
            s2_val_q     <= s1_sum_q >>> shift_q;
            s3_valid_q   <= s2_valid_q;
            s3_last_q    <= s2_last_q;
            s3_pix_q     <= pix_c;
            frame_done_q <= s3_valid_q & s3_last_q;
            if (s2_valid_q && clip_c) begin
                sat_q <= 1'b1;
            end
            if (s3_valid_q && fifo_full && !fifo_rd) begin
                ovf_q <= 1'b1;
            end
        end
    end

    sync_fifo #(
        .WIDTH (PIX_W),
        .DEPTH (FIFO_DEP)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (start),
        .wr_en_i   (s3_valid_q),
        .wr_data_i (s3_pix_q),
        .rd_en_i   (out_ready),
        .rd_data_o (out_data),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full)
    );

endmodule

// File: tb/tb_conv_output_stage.sv
// Scoreboard bench for conv_output_stage: directed frames and single-sample quantizer vectors.
module tb_conv_output_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [9:0]  img_w = '0;
    logic [9:0]  img_h = '0;
    logic [4:0]  frac_shift = '0;
    logic        relu_en = 1'b0;
    logic        mac_valid = 1'b0;
    logic [35:0] in_mac = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic        frame_done;
    logic        sat_flag;
    logic        ovf_err;
    logic [1:0]  dbg_state;

    logic [15:0] exp_q[$];
    int          chk_cnt = 0;
    int          pass_cnt = 0;
    int          out_cnt = 0;
    int          fd_cnt = 0;
    int          fd_cyc = 0;
    int          cyc = 0;
    int          last_kept_cyc = 0;
    bit          tog_en = 1'b0;

    conv_output_stage dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .img_w       (img_w),
        .img_h       (img_h),
        .frac_shift  (frac_shift),
        .relu_en     (relu_en),
        .mac_valid   (mac_valid),
        .in_mac      (in_mac),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .frame_done  (frame_done),
        .sat_flag    (sat_flag),
        .ovf_err     (ovf_err),
        .dbg_state_o (dbg_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: pops the expected queue on every accepted output
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_pixel", {20'h0, out_data}, 36'hF_FFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("pixel", {20'h0, out_data}, {20'h0, e});
                        out_cnt++;
                    end
                end else if (out_valid && exp_q.size() > 0) begin
                    check("head_hold", {20'h0, out_data}, {20'h0, exp_q[0]});
                end
                if (frame_done) begin
                    fd_cnt++;
                    fd_cyc = cyc;
                end
            end
        end
    end

    // Driver tasks
    task automatic step();
        @(posedge clk);
        #1;
        if (tog_en) out_ready = ~out_ready;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_start(input int w, input int h, input int sh, input bit relu);
        start = 1'b1;
        img_w = 10'(w);
        img_h = 10'(h);
        frac_shift = 5'(sh);
        relu_en = relu;
        step();
        start = 1'b0;
    endtask

    task automatic send(input logic [35:0] v, input bit push, input logic [15:0] e);
        mac_valid = 1'b1;
        in_mac = v;
        if (push) exp_q.push_back(e);
        step();
        mac_valid = 1'b0;
    endtask

    task automatic run_rows(input int w, input int r0, input int r1, input int gap,
                            input bit push, input int drop_lo, input int drop_hi);
        int k;
        for (int r = r0; r <= r1; r++) begin
            for (int c = 0; c < w; c++) begin
                k = r * (w - 2) + c;
                mac_valid = 1'b1;
                in_mac = 36'(c + 10 * r);
                if (push && c <= w - 3 && !(k >= drop_lo && k < drop_hi))
                    exp_q.push_back(16'(c + 10 * r));
                step();
                if (c <= w - 3) last_kept_cyc = cyc;
            end
            mac_valid = 1'b0;
            idle(gap);
        end
    endtask

    task automatic wait_drain(input int n);
        int i = 0;
        while ((exp_q.size() != 0 || out_valid) && i < n) begin
            step();
            i++;
        end
        check("drain_left", 36'(exp_q.size()), 36'd0);
    endtask

    task automatic run_one(input int sh, input bit relu, input logic [35:0] v,
                           input logic [15:0] e, input bit esat);
        do_start(3, 3, sh, relu);
        send(v, 1'b1, e);
        wait_drain(30);
        check("sat_flag", 36'(sat_flag), 36'(esat));
    endtask

    initial begin
        int o0, f0;
        logic [15:0] t1 [9] = '{16'd0, 16'd1, 16'd2, 16'd10, 16'd11, 16'd12, 16'd20, 16'd21, 16'd22};

        // Reset state
        idle(3);
        check("rst_out_valid", 36'(out_valid), 36'd0);
        check("rst_out_data", 36'(out_data), 36'd0);
        check("rst_frame_done", 36'(frame_done), 36'd0);
        check("rst_sat", 36'(sat_flag), 36'd0);
        check("rst_ovf", 36'(ovf_err), 36'd0);
        check("rst_state", 36'(dbg_state), 36'd0);
        rst = 1'b0;
        step();

        // Samples in IDLE are ignored
        send(36'd123, 1'b0, 16'd0);
        idle(6);
        check("idle_no_output", 36'(out_valid), 36'd0);

        // Test 1: 5x5 frame, pass-through quantizer
        o0 = out_cnt; f0 = fd_cnt;
        do_start(5, 5, 0, 0);
        foreach (t1[i]) exp_q.push_back(t1[i]);
        run_rows(5, 0, 2, 0, 1'b0, 0, 0);
        wait_drain(40);
        check("t1_count", 36'(out_cnt - o0), 36'd9);
        check("t1_frame_done_cnt", 36'(fd_cnt - f0), 36'd1);
        check("t1_frame_done_lat", 36'(fd_cyc - last_kept_cyc), 36'd3);
        check("t1_state_done", 36'(dbg_state), 36'd2);

        // Test 2: rounding and positive saturation
        run_one(4, 1'b0, 36'd24, 16'd2, 1'b0);
        run_one(4, 1'b0, 36'd23, 16'd1, 1'b0);
        run_one(4, 1'b0, 36'hF_FFFF_FFE8, 16'hFFFF, 1'b0);
        run_one(4, 1'b0, 36'h0_0010_0000, 16'h7FFF, 1'b1);

        // Test 3: ReLU and negative saturation
        run_one(0, 1'b1, 36'hF_FFFF_FFFB, 16'h0000, 1'b0);
        run_one(0, 1'b0, 36'hF_FFFF_63C0, 16'h8000, 1'b1);

        // Test 4: stalled consumer overflows the FIFO
        o0 = out_cnt; f0 = fd_cnt;
        out_ready = 1'b0;
        do_start(6, 6, 0, 0);
        run_rows(6, 0, 1, 0, 1'b1, 4, 8);
        idle(5);
        check("t4_ovf_set", 36'(ovf_err), 36'd1);
        check("t4_fifo_full_valid", 36'(out_valid), 36'd1);
        out_ready = 1'b1;
        wait_drain(30);
        run_rows(6, 2, 3, 0, 1'b1, 0, 0);
        wait_drain(40);
        check("t4_count", 36'(out_cnt - o0), 36'd12);
        check("t4_ovf_sticky", 36'(ovf_err), 36'd1);
        check("t4_frame_done_cnt", 36'(fd_cnt - f0), 36'd1);

        // Test 5: ready toggling every cycle, no loss
        o0 = out_cnt;
        do_start(6, 6, 0, 0);
        tog_en = 1'b1;
        run_rows(6, 0, 3, 2, 1'b1, 0, 0);
        wait_drain(60);
        tog_en = 1'b0;
        out_ready = 1'b1;
        check("t5_count", 36'(out_cnt - o0), 36'd16);
        check("t5_ovf_clear", 36'(ovf_err), 36'd0);

        // Test 6: reset mid-frame discards everything
        out_ready = 1'b0;
        do_start(6, 6, 0, 0);
        run_rows(6, 0, 0, 0, 1'b1, 0, 0);
        send(36'd10, 1'b0, 16'd0);
        idle(4);
        check("t6_ovf_before_rst", 36'(ovf_err), 36'd1);
        send(36'd11, 1'b0, 16'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        check("t6_rst_valid", 36'(out_valid), 36'd0);
        check("t6_rst_data", 36'(out_data), 36'd0);
        check("t6_rst_ovf", 36'(ovf_err), 36'd0);
        check("t6_rst_state", 36'(dbg_state), 36'd0);
        out_ready = 1'b1;
        o0 = out_cnt; f0 = fd_cnt;
        idle(6);
        check("t6_no_stale", 36'(out_cnt - o0), 36'd0);
        do_start(4, 4, 0, 0);
        run_rows(4, 0, 1, 0, 1'b1, 0, 0);
        wait_drain(30);
        check("t6_count", 36'(out_cnt - o0), 36'd4);
        check("t6_frame_done_cnt", 36'(fd_cnt - f0), 36'd1);
        check("t6_sat_clear", 36'(sat_flag), 36'd0);
        check("t6_ovf_clear", 36'(ovf_err), 36'd0);

        idle(2);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
